// File: rtl/store_unit_pkg.sv
// Shared types for the store path: operation encoding, atomic extension
// selection and the store FSM state.
package store_unit_pkg;

    typedef enum logic [3:0] {
        NOP,
        ADD,
        LB,
        LH,
        LW,
        LR_W,
        SB,
        SH,
        SW,
        SC_W
    } iType_e;

    typedef enum logic [1:0] {
        AMO_OFF,
        AMO_ZALRSC,
        AMO_A
    } atomic_e;

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } store_state_e;

    function automatic logic sc_supported(atomic_e ext);
        return (ext == AMO_A) || (ext == AMO_ZALRSC);
    endfunction

endpackage

// File: rtl/store_align.sv
// Byte-lane steering for stores: strobes, replicated write data and
// alignment check derived from the low address bits.
module store_align
    import store_unit_pkg::*;
(
    input  iType_e      operation_i,
    input  logic [1:0]  address_i,
    input  logic [31:0] store_data_i,
    output logic [3:0]  mem_we_o,
    output logic [31:0] mem_data_o,
    output logic        misaligned_o
);

    always_comb begin
        mem_we_o     = 4'b0000;
        mem_data_o   = 32'h0;
        misaligned_o = 1'b0;
        case (operation_i)
            SB: begin
                mem_we_o   = 4'b0001 << address_i;
                mem_data_o = {4{store_data_i[7:0]}};
            end
            SH: begin
                mem_we_o     = 4'b0011 << {address_i[1], 1'b0};
                mem_data_o   = {2{store_data_i[15:0]}};
                misaligned_o = address_i[0];
            end
            SW, SC_W: begin
                mem_we_o     = 4'b1111;
                mem_data_o   = store_data_i;
                misaligned_o = |address_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// Store issue unit: accepts stores from execute, holds the memory request
// until granted and reports completion, misalignment and SC_W outcome.
module store_unit
    import store_unit_pkg::*;
#(
    parameter atomic_e AMOEXT = AMO_A
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_i,
    output logic        ready_o,
    input  iType_e      instruction_operation_i,
    input  logic [31:0] address_i,
    input  logic [31:0] store_data_i,
    input  logic        sc_reserved_i,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [31:0] mem_address_o,
    output logic [3:0]  mem_we_o,
    output logic [31:0] mem_data_o,
    output logic        done_o,
    output logic        misaligned_o,
    output logic        sc_result_o,
    output logic        clear_reservation_o
);

    localparam logic SC_EN = sc_supported(AMOEXT);

    store_state_e state_q, state_d;
    logic [31:0]  mem_address_q, mem_address_d;
    logic [3:0]   mem_we_q, mem_we_d;
    logic [31:0]  mem_data_q, mem_data_d;
    logic         done_q, done_d;
    logic         misaligned_q, misaligned_d;
    logic         sc_result_q, sc_result_d;
    logic         clear_reservation_q, clear_reservation_d;
    logic         req_sc_q, req_sc_d;

    logic [3:0]   align_we;
    logic [31:0]  align_data;
    logic         align_misaligned;

    logic is_sc;
    logic is_store;
    logic accept;
    logic sc_fail;
    logic faulted;
    logic issue;
    logic granted;

    store_align u_store_align (
        .operation_i  (instruction_operation_i),
        .address_i    (address_i[1:0]),
        .store_data_i (store_data_i),
        .mem_we_o     (align_we),
        .mem_data_o   (align_data),
        .misaligned_o (align_misaligned)
    );

    always_comb begin
        is_sc    = SC_EN && (instruction_operation_i == SC_W);
        is_store = (instruction_operation_i == SB) || (instruction_operation_i == SH) ||
                   (instruction_operation_i == SW) || is_sc;
        ready_o  = (state_q == ST_IDLE) ? 1'b1 : mem_gnt_i;
        accept   = valid_i && ready_o && is_store;
        sc_fail  = is_sc && !sc_reserved_i;
        faulted  = accept && (align_misaligned || sc_fail);
        issue    = accept && !align_misaligned && !sc_fail;
        granted  = (state_q == ST_REQ) && mem_gnt_i;
    end

    always_comb begin
        state_d             = state_q;
        mem_address_d       = mem_address_q;
        mem_we_d            = mem_we_q;
        mem_data_d          = mem_data_q;
        req_sc_d            = req_sc_q;
        done_d              = granted || faulted;
        misaligned_d        = accept && align_misaligned;
        sc_result_d         = faulted && is_sc;
        // Every SC_W that finishes, by grant or by fault, drops the reservation.
        clear_reservation_d = (faulted && is_sc) || (granted && req_sc_q);

        if (issue) begin
            state_d       = ST_REQ;
            mem_address_d = {address_i[31:2], 2'b00};
            mem_we_d      = align_we;
            mem_data_d    = align_data;
            req_sc_d      = is_sc;
        end else if (granted) begin
            state_d  = ST_IDLE;
            mem_we_d = 4'b0000;
            req_sc_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q             <= ST_IDLE;
            mem_address_q       <= 32'h0;
            mem_we_q            <= 4'b0000;
            mem_data_q          <= 32'h0;
            done_q              <= 1'b0;
            misaligned_q        <= 1'b0;
            sc_result_q         <= 1'b0;
            clear_reservation_q <= 1'b0;
            req_sc_q            <= 1'b0;
        end else begin
            state_q             <= state_d;
            mem_address_q       <= mem_address_d;
            mem_we_q            <= mem_we_d;
            mem_data_q          <= mem_data_d;
            done_q              <= done_d;
            misaligned_q        <= misaligned_d;
            sc_result_q         <= sc_result_d;
            clear_reservation_q <= clear_reservation_d;
            req_sc_q            <= req_sc_d;
        end
    end

    assign mem_req_o           = (state_q == ST_REQ);
    assign mem_address_o       = mem_address_q;
    assign mem_we_o            = mem_we_q;
    assign mem_data_o          = mem_data_q;
    assign done_o              = done_q;
    assign misaligned_o        = misaligned_q;
    assign sc_result_o         = sc_result_q;
    assign clear_reservation_o = clear_reservation_q;

endmodule
